// File: rtl/regfile_ctrl_if.sv
// Register-file access bundle: two read ports, one write port, sweep status.
// master drives addresses/write data; slave (regfile_ctrl) returns read data and status.
interface regfile_ctrl_if;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        Busy;
   logic        WriteDropped;

   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      input  ReadData1, ReadData2, Busy, WriteDropped
   );

   modport slave (
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      output ReadData1, ReadData2, Busy, WriteDropped
   );
endinterface

// File: rtl/regfile_ctrl.sv
// 31x32 register file with post-reset clear sweep; address 0 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports.
module regfile_ctrl (
   input logic          Clk,
   input logic          Reset_n,
   regfile_ctrl_if.slave bus
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t      state, state_nxt;
   logic [4:0]  idx, idx_nxt;
   logic        wdrop;
   logic        busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] regs [1:31];

   assign busy             = (state == CLEAR);
   assign bus.Busy         = busy;
   assign bus.WriteDropped = wdrop;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= CLEAR;
         idx   <= 5'd1;
         wdrop <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         wdrop <= bus.RegWrite & busy;
      end
   end

   // The sweep and external writes share one storage write port.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wr_en     = 1'b0;
      wr_addr   = bus.WriteRegister;
      wr_data   = bus.WriteData;
      case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = idx;
            wr_data = '0;
            if (idx == 5'd31) begin
               state_nxt = READY;
            end else begin
               idx_nxt = idx + 5'd1;
            end
         end
         READY: begin
            wr_en = bus.RegWrite && (bus.WriteRegister != '0);
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Storage is deliberately not reset; only the sweep zeroes it.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] addr);
      logic [31:0] val;
      val = '0;
      if (!busy && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
         if (bus.RegWrite && (bus.WriteRegister == addr)) begin
            val = bus.WriteData;
         end else begin
            val = regs[addr];
         end
`else
         val = regs[addr];
`endif
      end
      return val;
   endfunction

   always_comb begin
      bus.ReadData1 = read_port(bus.ReadRegister1);
   end

   always_comb begin
      bus.ReadData2 = read_port(bus.ReadRegister2);
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_regfile_ctrl;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   regfile_ctrl_if rif ();

   regfile_ctrl dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (rif.slave)
   );

   always #5 Clk = ~Clk;

   int unsigned nchk = 0;
   int unsigned nerr = 0;
   bit          cmp_en = 1'b0;

   // Model: register contents, edges of sweep completed since reset, expected drop flag.
   logic [31:0] mdl [32];
   int unsigned sweep_cnt = 0;
   logic        mdl_wd = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic mdl_busy();
      return sweep_cnt < 31;
   endfunction

   function automatic logic [31:0] mdl_read(input logic [4:0] a);
      if (mdl_busy() || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (rif.RegWrite && rif.WriteRegister == a) return rif.WriteData;
`endif
      return mdl[a];
   endfunction

   always @(negedge Reset_n) begin
      sweep_cnt = 0;
      mdl_wd    = 1'b0;
   end

   always @(posedge Clk) begin
      if (Reset_n) begin
         if (mdl_busy()) begin
            mdl_wd = rif.RegWrite;
            sweep_cnt++;
            if (sweep_cnt == 31)
               for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
         end else begin
            mdl_wd = 1'b0;
            if (rif.RegWrite && rif.WriteRegister != 5'd0)
               mdl[rif.WriteRegister] = rif.WriteData;
         end
      end
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         chk("busy", {31'b0, rif.Busy}, {31'b0, mdl_busy()});
         chk("wdrop", {31'b0, rif.WriteDropped}, {31'b0, mdl_wd});
         chk("rd1", rif.ReadData1, mdl_read(rif.ReadRegister1));
         chk("rd2", rif.ReadData2, mdl_read(rif.ReadRegister2));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rif.RegWrite = 1'b1;
      rif.WriteRegister = a;
      rif.WriteData = d;
      step();
      rif.RegWrite = 1'b0;
   endtask

   // Releases reset, then counts rising edges until Busy drops (bounded).
   task automatic release_and_count(output int unsigned n);
      n = 0;
      Reset_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         n++;
         if (!rif.Busy) break;
      end
      if (rif.Busy) begin
         nchk++;
         nerr++;
         $display("FAIL sweep_timeout: Busy still high after %0d edges, required low", n);
      end
   endtask

   int unsigned edges;
   logic [4:0]  a;

   initial begin
      rif.ReadRegister1 = '0;
      rif.ReadRegister2 = '0;
      rif.WriteRegister = '0;
      rif.WriteData     = '0;
      rif.RegWrite      = 1'b0;
      #1;
      cmp_en = 1'b1;
      step();
      step();
      chk("rst_busy", {31'b0, rif.Busy}, 32'd1);
      chk("rst_wdrop", {31'b0, rif.WriteDropped}, 32'd0);

      // Sweep length and all-zero contents afterwards
      rif.ReadRegister1 = 5'd17;
      release_and_count(edges);
      chk("sweep_edges", edges, 32'd31);
      for (int i = 0; i < 32; i++) begin
         rif.ReadRegister1 = 5'(i);
         rif.ReadRegister2 = 5'(31 - i);
         #1;
         chk("post_sweep_rd1", rif.ReadData1, 32'h0);
      end
      step();

      // Consecutive writes, and RegWrite=0 ignored
      rif.ReadRegister1 = 5'd2;
      rif.ReadRegister2 = 5'd2;
      wr(5'd2, 32'd42);
      chk("w42_p1", rif.ReadData1, 32'd42);
      chk("w42_p2", rif.ReadData2, 32'd42);
      wr(5'd2, 32'd15);
      chk("w15_p1", rif.ReadData1, 32'd15);
      rif.WriteRegister = 5'd5;
      rif.WriteData = 32'd37;
      rif.ReadRegister1 = 5'd5;
      step();
      chk("nowrite_r5", rif.ReadData1, 32'h0);

      // Write to reg 0 is a no-op and not a drop
      wr(5'd2, 32'd26);
      rif.ReadRegister1 = 5'd2;
      rif.ReadRegister2 = 5'd31;
      #1;
      chk("w26_p1", rif.ReadData1, 32'd26);
      chk("w26_p2", rif.ReadData2, 32'd0);
      rif.ReadRegister1 = 5'd0;
      rif.ReadRegister2 = 5'd0;
      wr(5'd0, 32'd89);
      chk("r0_p1", rif.ReadData1, 32'h0);
      chk("r0_wdrop", {31'b0, rif.WriteDropped}, 32'd0);

      // Fill i -> reg i, cross-read
      for (int i = 0; i < 32; i++) wr(5'(i), 32'(i));
      for (int i = 0; i < 32; i++) begin
         rif.ReadRegister1 = 5'(i);
         rif.ReadRegister2 = 5'(31 - i);
         #1;
         chk("fill_p1", rif.ReadData1, 32'(i));
         chk("fill_p2", rif.ReadData2, (i == 31) ? 32'h0 : 32'(31 - i));
      end
      step();

      // Same-cycle read of a pending write
      rif.ReadRegister1 = 5'd7;
      rif.RegWrite = 1'b1;
      rif.WriteRegister = 5'd7;
      rif.WriteData = 32'h12345678;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_pre", rif.ReadData1, 32'h12345678);
`else
      chk("nobypass_pre", rif.ReadData1, 32'd7);
`endif
      step();
      rif.RegWrite = 1'b0;
      chk("bypass_post", rif.ReadData1, 32'h12345678);

      // Dropped write during sweep, then reset mid-sweep
      wr(5'd9, 32'h0000AAAA);
      Reset_n = 1'b0;
      step();
      Reset_n = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("drop_busy", {31'b0, rif.Busy}, 32'd1);
      wr(5'd9, 32'hDEADBEEF);
      chk("drop_pulse", {31'b0, rif.WriteDropped}, 32'd1);
      step();
      chk("drop_clear", {31'b0, rif.WriteDropped}, 32'd0);
      for (int k = 0; k < 3; k++) step();
      Reset_n = 1'b0;
      step();
      chk("midrst_wdrop", {31'b0, rif.WriteDropped}, 32'd0);
      step();
      release_and_count(edges);
      chk("resweep_edges", edges, 32'd31);
      rif.ReadRegister1 = 5'd9;
      #1;
      chk("drop_target", rif.ReadData1, 32'h0);
      step();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         a = 5'($urandom_range(0, 31));
         rif.RegWrite = ($urandom_range(0, 3) != 0);
         rif.WriteRegister = a;
         rif.WriteData = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         rif.ReadRegister1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
         rif.ReadRegister2 = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 299) == 0) begin
            Reset_n = 1'b0;
            step();
            Reset_n = 1'b1;
         end else begin
            step();
         end
      end
      rif.RegWrite = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
